// File: rtl/controle_remoto_tx_pkg.sv
// Shared types and timing defaults for the key-fob transmitter.
// Counter widths are derived here so the top and debouncer agree.
package controle_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        GAP      = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

    localparam int DEB_CYCLES_DEF   = 4;
    localparam int PULSE_CYCLES_DEF = 8;
    localparam int GAP_CYCLES_DEF   = 8;

    // Never return zero, so a parameter set of all ones still yields a legal vector.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/controle_remoto_tx_if.sv
// Fob-side bundle: raw button/enable in, press pulse and debug status out.
// The master side is the harness driving the fob; the slave side is the transmitter.
interface controle_remoto_tx_if;

    logic       button;
    logic       enable;
    logic       remote;
    logic       busy;
    logic [7:0] tx_count;

    modport master (
        output button,
        output enable,
        input  remote,
        input  busy,
        input  tx_count
    );

    modport slave (
        input  button,
        input  enable,
        output remote,
        output busy,
        output tx_count
    );

endinterface

// File: rtl/controle_remoto_tx_debounce_botao.sv
// Two-flop synchronizer plus persistence filter for the raw push-button.
// A new level is accepted only after it has held for DEB_CYCLES samples.
module debounce_botao
    import controle_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic button_i,
    output logic btn_db_o
);

    localparam int W = cnt_w(DEB_CYCLES, 1, 1);
    localparam logic [W-1:0] LAST = W'(DEB_CYCLES - 1);

    logic         s1_q;
    logic         s2_q;
    logic         db_q;
    logic         db_d;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == LAST) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= button_i;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign btn_db_o = db_q;

endmodule

// File: rtl/controle_remoto_tx.sv
// Key-fob transmitter: one fixed-width remote pulse per clean press,
// followed by a guaranteed low gap and a wait for button release.
module controle_remoto_tx
    import controle_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    controle_remoto_tx_if.slave  bus
);

    localparam int W = cnt_w(PULSE_CYCLES, GAP_CYCLES, DEB_CYCLES);
    localparam logic [W-1:0] PULSE_LD = W'(PULSE_CYCLES - 1);
    localparam logic [W-1:0] GAP_LD   = W'(GAP_CYCLES - 1);

    logic         btn_db;
    logic         btn_db_q;
    logic         press;
    state_e       state_q;
    state_e       state_d;
    logic [W-1:0] tmr_q;
    logic [W-1:0] tmr_d;
    logic [7:0]   cnt_q;
    logic [7:0]   cnt_d;
    logic         remote_q;
    logic         remote_d;
    logic         busy_q;
    logic         busy_d;

    debounce_botao #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk      (clk),
        .rst      (rst),
        .button_i (bus.button),
        .btn_db_o (btn_db)
    );

    // Rising edge of the filtered level, gated by enable in the same cycle.
    assign press = btn_db & ~btn_db_q & bus.enable;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = PULSE;
                    tmr_d   = PULSE_LD;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            PULSE: begin
                if (tmr_q == '0) begin
                    state_d = GAP;
                    tmr_d   = GAP_LD;
                end else begin
                    tmr_d = tmr_q - W'(1);
                end
            end
            GAP: begin
                if (tmr_q == '0) begin
                    state_d = WAIT_REL;
                end else begin
                    tmr_d = tmr_q - W'(1);
                end
            end
            WAIT_REL: begin
                if (!btn_db) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs follow the next state so they switch on the same edge.
        remote_d = (state_d == PULSE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            cnt_q    <= 8'd0;
            btn_db_q <= 1'b0;
            remote_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            btn_db_q <= btn_db;
            remote_q <= remote_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.remote   = remote_q;
    assign bus.busy     = busy_q;
    assign bus.tx_count = cnt_q;

endmodule

// File: doc/controle_remoto_tx.md
Name: controle_remoto_tx

Overview:
- Key-fob transmitter that drives the single-bit `remote` line consumed by the car-alarm FSM.
- Converts a raw, bouncing push-button into one clean, fixed-width press pulse, followed by a guaranteed low gap. The alarm therefore always sees a distinct press and a distinct release.
- Sits on the fob/test-harness side and connects directly to the alarm's `remote` input.
- Also counts transmitted presses for debug.

Parameters:
- DEB_CYCLES, 4, number of consecutive cycles a synchronized button level must persist before it is accepted (≥1).
- PULSE_CYCLES, 8, number of cycles `remote` is held high per press (≥1).
- GAP_CYCLES, 8, minimum number of cycles `remote` is held low after each pulse before another press can be sent (≥1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; one clock, no other clock domains.
- button  in  1  raw push-button, asynchronous to clk, may bounce.
- enable  in  1  1 = presses may be transmitted; 0 = new presses ignored.
- remote  out  1  registered press pulse to the alarm.
- busy  out  1  registered; 1 whenever the FSM is not in IDLE.
- tx_count  out  8  registered count of pulses sent; wraps 255→0.

Behaviour:
- Reset (async, rst=1): all outputs and internal state return to their initial values immediately, mid-pulse included.
  - remote=0, busy=0, tx_count=0, state=IDLE.
  - Synchronizer flops=0, btn_db=0, debounce counter=0, btn_db_q=0.
- Synchronizer: two flops, s1←button then s2←s1.
- Debounce:
  - If s2==btn_db, the counter is cleared.
  - Otherwise the counter increments. When the counter reaches DEB_CYCLES−1 and s2 still differs, btn_db←s2 and the counter clears.
  - Any reversal before that clears the counter, so glitches shorter than DEB_CYCLES cycles are ignored.
- Press event: press = btn_db & ~btn_db_q & enable, where btn_db_q is btn_db delayed by one cycle. A press is an edge, not a level.
- Latency: with button high at sampling edge 1, btn_db rises at edge 2+DEB_CYCLES and remote rises at edge 3+DEB_CYCLES. For defaults, remote rises at edge 7.
- FSM states and transitions:
  - IDLE: remote=0, busy=0. press → PULSE, load counter with PULSE_CYCLES−1, tx_count+1.
  - PULSE: remote=1, busy=1. Counter decrements; at 0 → GAP, load counter with GAP_CYCLES−1.
    - remote is high for exactly PULSE_CYCLES cycles.
    - Dropping enable or releasing the button does not truncate the pulse.
  - GAP: remote=0, busy=1. Counter decrements; at 0 → WAIT_REL. Presses during GAP are discarded.
  - WAIT_REL: remote=0, busy=1. btn_db==0 → IDLE.
    - Holding the button produces exactly one pulse, with no auto-repeat.
    - If the button was already released, WAIT_REL lasts one cycle.
- Outputs are decoded from the next state and registered, so they change on the same edge as the state.
- tx_count: increments on the IDLE→PULSE edge only; 8-bit unsigned modulo-256 wrap.
- enable:
  - Sampled only in IDLE.
  - A press that arrives while enable=0 is lost, even if enable rises while the button is still held, because there is no new edge.
- Simultaneous events: rst wins over everything. press and enable falling in the same cycle means no press, because enable is sampled in that same cycle.

Decomposition:
- Shared package controle_pkg:
  - 2-bit state encoding localparams IDLE=0, PULSE=1, GAP=2, WAIT_REL=3.
  - Default timing constants.
  - Counter-width function (clog2 of the max of PULSE_CYCLES, GAP_CYCLES, DEB_CYCLES).
- One sub-module, debounce_botao:
  - Contains the synchronizer and debounce counter, parameterized by DEB_CYCLES.
  - Outputs btn_db.
  - Takes clk/rst with the same async active-high reset.
- The top level holds the edge detect, FSM, timer and tx_count.

Test Plan:
- Clean press, defaults: button high 30 cycles from edge 1, enable=1 → remote high edges 7..14 (8 cycles), busy high edges 7..30+, tx_count=1, remote never rises again while held.
- Bounce: button toggles high 3 cycles, low 1, high 3, then low → remote stays 0, tx_count=0. Then high for 10 cycles → exactly one pulse.
- Re-press during GAP: press, release at PULSE end, press again 2 cycles into GAP and hold 3 cycles → ignored, tx_count=1. Press after busy falls → second pulse, tx_count=2.
- enable=0 during press, enable→1 while button still held → no pulse. Release then press → pulse.
- rst asserted asynchronously mid-PULSE (cycle 4 of 8) → remote, busy, tx_count go to 0 immediately. After release of rst, a fresh press gives a full 8-cycle pulse.
- 257 spaced presses (PULSE_CYCLES=1, GAP_CYCLES=1, DEB_CYCLES=1) → tx_count reads 255 after 255 presses, 0 after 256, 1 after 257.
